dma_axi_rd_master: RTL and testbench

- DMA read engine driving the AR/R channels of the DMA AXI bus as master.
- Accepts one read command (start address, beat count), splits it into AXI3 INCR bursts (max 16 beats, never crossing 4 KB), and streams returned read data to the downstream write-side FIFO.
- Sits between the DMA channel controller (upstream) and the AXI slave/interconnect (downstream on AR/R).

---
 rtl/axi_data_types_pkg.sv | 18 +
 rtl/dma_rd_pkg.sv | 12 +
 rtl/dma_skid_fifo.sv | 58 +++++
 rtl/dma_axi_rd_master.sv | 193 +++++++++++++++++++
 tb/tb_dma_axi_rd_master.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_data_types_pkg.sv
// Shared AXI3 field types and response/boundary constants used across the DMA bus masters.
package axi_data_types_pkg;

   typedef logic [3:0]  axi_id;
   typedef logic [31:0] axi_address;
   typedef logic [3:0]  axi_burst_length;
   typedef logic [2:0]  axi_burst_size;
   typedef logic [63:0] axi_data;
   typedef logic [1:0]  axi_response;

   localparam axi_response RESP_OKAY   = 2'b00;
   localparam axi_response RESP_EXOKAY = 2'b01;
   localparam axi_response RESP_SLVERR = 2'b10;
   localparam axi_response RESP_DECERR = 2'b11;

   localparam int AXI_4KB = 4096;

endpackage

// File: rtl/dma_rd_pkg.sv
// State encoding for the DMA read master burst sequencer.
package dma_rd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      DRAIN,
      DONE
   } dma_rd_state_e;

endpackage

// File: rtl/dma_skid_fifo.sv
// Two-entry skid FIFO with registered head; in_ready depends only on occupancy, never on out_ready.
module dma_skid_fifo #(
   parameter int WIDTH = 65
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [1:0]       count_q, count_d;
   logic             push, pop;

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign out_data  = head_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      push    = in_valid && in_ready;
      pop     = out_valid && out_ready;
      case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) head_d = in_data;
            else                 tail_d = in_data;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         // push and pop together only happens with exactly one entry held
         2'b11: head_d = in_data;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/dma_axi_rd_master.sv
// DMA read master: splits one command into AXI3 INCR bursts (<= MAX_BURST, never crossing 4 KB).
// Define DMA_RD_RID_CHECK_EN to flag R beats whose rid differs from the command id.
module dma_axi_rd_master
   import axi_data_types_pkg::*;
   import dma_rd_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int ID_W      = 4,
   parameter int CNT_W     = 16,
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [CNT_W-1:0]  cmd_beats,
   input  logic [ID_W-1:0]   cmd_id,
   output logic [ID_W-1:0]   arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [3:0]        arlen,
   output logic [2:0]        arsize,
   output logic              arvalid,
   input  logic              arready,
   input  logic [ID_W-1:0]   rid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [DATA_W-1:0] dout_data,
   output logic              dout_last,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int BYTES = DATA_W / 8;
   localparam int SHIFT = $clog2(BYTES);

   dma_rd_state_e     state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [3:0]        arlen_q, arlen_d;
   logic [3:0]        beat_cnt_q, beat_cnt_d;
   logic              err_q, err_d;

   logic              fifo_ready, push_valid, push_last;
   logic              final_cnt, burst_end, rid_err;
   logic [ADDR_W-1:0] cmd_addr_aligned;
   logic [DATA_W:0]   fifo_out;

   // Beats in the next burst: limited by what is left, MAX_BURST and the distance to the 4 KB page end.
   function automatic logic [4:0] burst_beats(input logic [ADDR_W-1:0] a,
                                              input logic [CNT_W-1:0]  rem);
      logic [12:0] page_beats;
      logic [12:0] n;
      page_beats = (13'(AXI_4KB) - {1'b0, a[11:0]}) >> SHIFT;
      n          = 13'(MAX_BURST);
      if (page_beats < n) n = page_beats;
      if (rem < CNT_W'(n)) n = 13'(rem);
      return n[4:0];
   endfunction

`ifdef DMA_RD_RID_CHECK_EN
   assign rid_err = (rid != id_q);
`else
   logic unused_rid;
   assign rid_err    = 1'b0;
   assign unused_rid = ^rid;
`endif

   assign cmd_addr_aligned = cmd_addr & ~ADDR_W'(BYTES - 1);
   assign arid             = id_q;
   assign araddr           = addr_q;
   assign arlen            = arlen_q;
   assign arsize           = 3'(SHIFT);
   assign busy             = (state_q != IDLE);
   assign err              = err_q;
   assign dout_last        = fifo_out[DATA_W];
   assign dout_data        = fifo_out[DATA_W-1:0];

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      id_d        = id_q;
      arlen_d     = arlen_q;
      beat_cnt_d  = beat_cnt_q;
      err_d       = err_q;
      cmd_ready   = 1'b0;
      arvalid     = 1'b0;
      rready      = 1'b0;
      done        = 1'b0;
      push_valid  = 1'b0;
      push_last   = 1'b0;
      final_cnt   = 1'b0;
      burst_end   = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               err_d = 1'b0;
               id_d  = cmd_id;
               if (cmd_beats == '0) begin
                  state_d = DONE;
               end else begin
                  addr_d      = cmd_addr_aligned;
                  remaining_d = cmd_beats;
                  arlen_d     = 4'(burst_beats(cmd_addr_aligned, cmd_beats) - 5'd1);
                  state_d     = ADDR;
               end
            end
         end
         ADDR: begin
            arvalid = 1'b1;
            if (arready) begin
               addr_d      = addr_q + ((ADDR_W'(arlen_q) + ADDR_W'(1)) << SHIFT);
               remaining_d = remaining_q - CNT_W'(arlen_q) - CNT_W'(1);
               beat_cnt_d  = 4'd0;
               state_d     = DATA;
            end
         end
         DATA: begin
            rready = fifo_ready;
            if (rvalid && fifo_ready) begin
               // A burst ends on rlast or on the expected count; disagreement between the two is an error.
               push_valid = 1'b1;
               final_cnt  = (beat_cnt_q == arlen_q);
               burst_end  = rlast || final_cnt;
               push_last  = burst_end && (remaining_q == '0);
               beat_cnt_d = beat_cnt_q + 4'd1;
               if ((rresp != RESP_OKAY) || (rlast != final_cnt) || rid_err) err_d = 1'b1;
               if (burst_end) begin
                  beat_cnt_d = 4'd0;
                  if (remaining_q != '0) begin
                     arlen_d = 4'(burst_beats(addr_q, remaining_q) - 5'd1);
                     state_d = ADDR;
                  end else begin
                     state_d = DRAIN;
                  end
               end
            end
         end
         DRAIN: begin
            if (!dout_valid) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         id_q        <= '0;
         arlen_q     <= 4'd0;
         beat_cnt_q  <= 4'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         id_q        <= id_d;
         arlen_q     <= arlen_d;
         beat_cnt_q  <= beat_cnt_d;
         err_q       <= err_d;
      end
   end

   dma_skid_fifo #(
      .WIDTH (DATA_W + 1)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (push_valid),
      .in_ready  (fifo_ready),
      .in_data   ({push_last, rdata}),
      .out_valid (dout_valid),
      .out_ready (dout_ready),
      .out_data  (fifo_out)
   );

endmodule

// File: tb/tb_dma_axi_rd_master.sv
// Directed bench for dma_axi_rd_master: a small AXI slave and stream sink model run alongside the stimulus.
module tb_dma_axi_rd_master;

   typedef struct packed {
      logic [2:0]  size;
      logic [3:0]  id;
      logic [3:0]  len;
      logic [31:0] addr;
   } ar_rec_t;

   logic        clk, rst;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_addr;
   logic [15:0] cmd_beats;
   logic [3:0]  cmd_id;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;
   logic        dout_valid, dout_ready;
   logic [63:0] dout_data;
   logic        dout_last, busy, done, err;

   ar_rec_t     ar_log[$];
   ar_rec_t     exp_ar[$];
   ar_rec_t     ar_cap;
   logic [64:0] out_log[$];
   logic [64:0] d_cap;
   logic        ar_hs = 1'b0, r_hs = 1'b0, d_hs = 1'b0, r_active = 1'b0;
   logic        rready_low_seen = 1'b0;
   logic [31:0] r_addr = '0;
   logic [3:0]  r_len = '0, r_id = '0;
   int          r_idx = 0, g_idx = 0, ar_wait = 0, stall_left = 0, done_count = 0;
   int          stall_at = -1, slverr_beat = -1, bad_rid_beat = -1;
   int          check_count = 0, pass_count = 0;

   dma_axi_rd_master dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_beats  (cmd_beats),
      .cmd_id     (cmd_id),
      .arid       (arid),
      .araddr     (araddr),
      .arlen      (arlen),
      .arsize     (arsize),
      .arvalid    (arvalid),
      .arready    (arready),
      .rid        (rid),
      .rdata      (rdata),
      .rresp      (rresp),
      .rlast      (rlast),
      .rvalid     (rvalid),
      .rready     (rready),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_data  (dout_data),
      .dout_last  (dout_last),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Slave and sink act at negedge+1; handshakes are predicted from values held stable until the next posedge.
   initial begin : bus_model
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rid = '0; rdata = '0; rresp = 2'b00;
      dout_ready = 1'b1;
      forever begin
         @(negedge clk); #1;
         if (!rst) begin
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; dout_ready = 1'b1;
            r_active = 1'b0; ar_hs = 1'b0; r_hs = 1'b0; d_hs = 1'b0;
            ar_wait = 0; stall_left = 0;
            continue;
         end
         if (r_hs) begin
            g_idx++;
            if (r_idx == int'(r_len)) r_active = 1'b0;
            else r_idx++;
         end
         if (ar_hs) begin
            ar_log.push_back(ar_cap);
            r_active = 1'b1; r_addr = ar_cap.addr; r_len = ar_cap.len; r_id = ar_cap.id; r_idx = 0;
         end
         if (d_hs) out_log.push_back(d_cap);
         if (done) done_count++;
         if (stall_at >= 0 && out_log.size() == stall_at) begin
            stall_left = 10;
            stall_at   = -1;
         end
         dout_ready = (stall_left == 0);
         if (stall_left > 0) stall_left--;
         arready = arvalid && !r_active && (ar_wait >= 1);
         if (arvalid && !arready) ar_wait++;
         rvalid = r_active;
         rlast  = r_active && (r_idx == int'(r_len));
         rdata  = {32'(g_idx), r_addr + 32'(r_idx * 8)};
         rresp  = (r_active && g_idx == slverr_beat) ? 2'b10 : 2'b00;
         rid    = (r_active && g_idx == bad_rid_beat) ? 4'd3 : r_id;
         ar_hs  = arvalid && arready;
         if (ar_hs) begin
            ar_cap  = '{size: arsize, id: arid, len: arlen, addr: araddr};
            ar_wait = 0;
         end
         r_hs = rvalid && rready;
         if (rvalid && !rready) rready_low_seen = 1'b1;
         d_hs  = dout_valid && dout_ready;
         d_cap = {dout_last, dout_data};
      end
   end

   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] beats, input logic [3:0] id);
      ar_log.delete(); out_log.delete();
      done_count = 0; g_idx = 0; rready_low_seen = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = addr; cmd_beats = beats; cmd_id = id;
      for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic waitDone(output int cyc);
      cyc = 1;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("done_seen", 128'(done), 128'(1));
   endtask

   task automatic verifyCommand(input logic [31:0] base, input int beats, input logic exp_err);
      logic [64:0] exp_beat;
      checkOutput("ar_count", 128'(ar_log.size()), 128'(exp_ar.size()));
      for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++)
         checkOutput($sformatf("ar%0d", i), 128'(ar_log[i]), 128'(exp_ar[i]));
      checkOutput("beat_count", 128'(out_log.size()), 128'(beats));
      for (int k = 0; k < beats && k < out_log.size(); k++) begin
         exp_beat = {(k == beats - 1), 32'(k), base + 32'(k * 8)};
         checkOutput($sformatf("beat%0d", k), 128'(out_log[k]), 128'(exp_beat));
      end
      checkOutput("done_pulses", 128'(done_count), 128'(1));
      checkOutput("err_final", 128'(err), 128'(exp_err));
   endtask

   task automatic runCommand(input logic [31:0] addr, input logic [31:0] base, input int beats,
                             input logic [3:0] id, input logic exp_err);
      int cyc;
      applyStimulus(addr, 16'(beats), id);
      checkOutput("accept_ready_busy", 128'({cmd_ready, busy}), 128'(2'b01));
      checkOutput("err_cleared", 128'(err), 128'(0));
      if (beats != 0)
         checkOutput("first_ar", 128'({arvalid, araddr, arlen}), 128'({1'b1, exp_ar[0].addr, exp_ar[0].len}));
      else
         checkOutput("zero_no_ar", 128'({arvalid, done}), 128'(2'b01));
      waitDone(cyc);
      if (beats == 0) checkOutput("zero_done_latency", 128'(cyc), 128'(1));
      checkOutput("busy_in_done", 128'(busy), 128'(1));
      @(negedge clk);
      checkOutput("idle_after_done", 128'({done, busy, cmd_ready}), 128'(3'b001));
      verifyCommand(base, beats, exp_err);
   endtask

   initial begin : stimulus
      logic rid_exp;
      rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0; cmd_id = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_state",
                  128'({cmd_ready, arvalid, rready, dout_valid, dout_last, busy, done, err, arsize, arid, araddr, arlen}),
                  128'({8'b1000_0000, 3'd3, 4'd0, 32'd0, 4'd0}));
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Single full burst
      exp_ar.delete();
      exp_ar.push_back('{3'd3, 4'd1, 4'd15, 32'h1000});
      runCommand(32'h1000, 32'h1000, 16, 4'd1, 1'b0);

      // Split into three bursts
      exp_ar.delete();
      exp_ar.push_back('{3'd3, 4'd2, 4'd15, 32'h0000});
      exp_ar.push_back('{3'd3, 4'd2, 4'd15, 32'h0080});
      exp_ar.push_back('{3'd3, 4'd2, 4'd7,  32'h0100});
      runCommand(32'h0000, 32'h0000, 40, 4'd2, 1'b0);

      // 4 KB page boundary
      exp_ar.delete();
      exp_ar.push_back('{3'd3, 4'd3, 4'd3, 32'h0FE0});
      exp_ar.push_back('{3'd3, 4'd3, 4'd3, 32'h1000});
      runCommand(32'h0FE0, 32'h0FE0, 8, 4'd3, 1'b0);

      // Sink stall plus SLVERR on one beat
      exp_ar.delete();
      exp_ar.push_back('{3'd3, 4'd4, 4'd15, 32'h2000});
      exp_ar.push_back('{3'd3, 4'd4, 4'd7,  32'h2080});
      stall_at = 5; slverr_beat = 3;
      runCommand(32'h2000, 32'h2000, 24, 4'd4, 1'b1);
      checkOutput("rready_dropped", 128'(rready_low_seen), 128'(1));
      slverr_beat = -1;

      // Next command clears err; unaligned address low bits are dropped
      exp_ar.delete();
      exp_ar.push_back('{3'd3, 4'd4, 4'd2, 32'h0040});
      runCommand(32'h0045, 32'h0040, 3, 4'd4, 1'b0);

      // Zero-beat command
      exp_ar.delete();
      runCommand(32'h0800, 32'h0800, 0, 4'd1, 1'b0);

      // Reset while data is in flight
      applyStimulus(32'h3000, 16'd16, 4'd6);
      for (int i = 0; i < 500 && out_log.size() < 3; i++) @(negedge clk);
      checkOutput("mid_burst_reached", 128'(out_log.size() >= 3), 128'(1));
      rst = 1'b0;
      #1;
      checkOutput("reset_mid_op",
                  128'({cmd_ready, arvalid, rready, dout_valid, dout_last, busy, done, err, arid, araddr, arlen}),
                  128'({8'b1000_0000, 4'd0, 32'd0, 4'd0}));
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      exp_ar.delete();
      exp_ar.push_back('{3'd3, 4'd7, 4'd3, 32'h0500});
      runCommand(32'h0500, 32'h0500, 4, 4'd7, 1'b0);

      // Wrong rid on one beat
`ifdef DMA_RD_RID_CHECK_EN
      rid_exp = 1'b1;
`else
      rid_exp = 1'b0;
`endif
      exp_ar.delete();
      exp_ar.push_back('{3'd3, 4'd5, 4'd3, 32'h0600});
      bad_rid_beat = 2;
      runCommand(32'h0600, 32'h0600, 4, 4'd5, rid_exp);
      bad_rid_beat = -1;

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
